// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - shared constants, event entry type and word packing for key_event_ctrl
package key_event_pkg;

  localparam logic [1:0] ADDR_EVENT    = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_CONTROL  = 2'd3;

  localparam int VALID_BIT = 31;
  localparam int TS_LSB    = 8;
  localparam int TS_WIDTH  = 16;
  localparam int PRESS_BIT = 4;
  localparam int IDX_WIDTH = 3;

  localparam int STATUS_STABLE_LSB = 0;
  localparam int STATUS_COUNT_LSB  = 8;
  localparam int STATUS_OVF_BIT    = 16;

  localparam int ENTRY_WIDTH = TS_WIDTH + 1 + IDX_WIDTH;

  typedef struct packed {
    logic [TS_WIDTH-1:0]  ts;
    logic                 press;
    logic [IDX_WIDTH-1:0] idx;
  } event_entry_t;

  // Expand a stored 20-bit entry into the host-visible EVENT word.
  function automatic logic [31:0] event_word(input event_entry_t e);
    logic [31:0] w;
    w = '0;
    w[VALID_BIT] = 1'b1;
    w[TS_LSB +: TS_WIDTH] = e.ts;
    w[PRESS_BIT] = e.press;
    w[IDX_WIDTH-1:0] = e.idx;
    return w;
  endfunction

endpackage

// File: rtl/key_event_ctrl_if.sv
// rtl/key_event_ctrl_if.sv - Avalon-MM slave bus bundle for key_event_ctrl
interface key_event_ctrl_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser and stable-count debouncer for one key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key,
  output logic o_stable,
  output logic o_event,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  logic w_differs;
  logic w_accept;

  assign w_differs = (r_sync2 != r_stable);
  assign w_accept  = w_differs && (r_cnt == LAST_COUNT);

  // Event is combinational so the top can set pending on the same edge the level is accepted.
  assign o_stable = r_stable;
  assign o_event  = w_accept;
  assign o_press  = ~r_sync2;

  // Synchronise the pin, count consecutive differing cycles and accept the new level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - debounced key events, round-robin scheduling into a timestamped FIFO with irq
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] in_port,
  key_event_ctrl_if.slave     bus
);

  localparam int RRW  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(FIFO_DEPTH);

  logic [NUM_KEYS-1:0] w_stable;
  logic [NUM_KEYS-1:0] w_event;
  logic [NUM_KEYS-1:0] w_press;

  logic [NUM_KEYS-1:0] r_pending;
  logic [NUM_KEYS-1:0] r_ptype;
  logic [RRW-1:0]      r_rr;
  logic [15:0]         r_ts;

  event_entry_t        r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wp;
  logic [AW-1:0]       r_rp;
  logic [CNTW-1:0]     r_count;
  logic                r_ovf;
  logic [1:0]          r_mask;
  logic [31:0]         r_readdata;

  logic                w_grant_valid;
  logic [RRW-1:0]      w_grant_idx;
  logic [NUM_KEYS-1:0] w_grant_clr;
  logic [RRW-1:0]      w_rr_next;

  logic                w_rd;
  logic                w_wr;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_flush;
  logic                w_ovf_clr;
  logic                w_push_ok;
  logic                w_ovf_set;
  event_entry_t        w_new;
  logic [31:0]         w_status;
  logic                w_unused;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .i_key   (in_port[gi]),
      .o_stable(w_stable[gi]),
      .o_event (w_event[gi]),
      .o_press (w_press[gi])
    );
  end

  // Round-robin: lowest pending index at or after r_rr, wrapping.
  always_comb begin
    int j;
    j             = 0;
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    w_grant_clr   = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      j = (int'(r_rr) + k) % NUM_KEYS;
      if (!w_grant_valid && r_pending[j]) begin
        w_grant_valid  = 1'b1;
        w_grant_idx    = RRW'(j);
        w_grant_clr[j] = 1'b1;
      end
    end
  end

  assign w_rr_next = (w_grant_idx == RRW'(NUM_KEYS - 1)) ? '0 : w_grant_idx + RRW'(1);

  assign w_rd      = bus.chipselect && !bus.read_n;
  assign w_wr      = bus.chipselect && !bus.write_n;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_COUNT);
  assign w_pop     = w_rd && (bus.address == ADDR_EVENT) && !w_empty;
  assign w_flush   = w_wr && (bus.address == ADDR_CONTROL) && bus.writedata[0];
  assign w_ovf_clr = w_wr && (bus.address == ADDR_CONTROL) && bus.writedata[1];
  // A pop on the same edge frees the slot the push needs; flush discards the push outright.
  assign w_push_ok = w_grant_valid && (!w_full || w_pop) && !w_flush;
  assign w_ovf_set = w_grant_valid && w_full && !w_pop && !w_flush;

  assign w_new.ts    = r_ts;
  assign w_new.press = r_ptype[w_grant_idx];
  assign w_new.idx   = IDX_WIDTH'(w_grant_idx);

  assign w_unused = ^bus.writedata[31:2];

  // Pending events: a fresh debounce event wins over a grant clearing the same key.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_ptype   <= '0;
      r_rr      <= '0;
    end else begin
      r_pending <= (r_pending & ~w_grant_clr) | w_event;
      r_ptype   <= (r_ptype & ~w_event) | (w_press & w_event);
      if (w_grant_valid) begin
        r_rr <= w_rr_next;
      end
    end
  end

  // Free-running timestamp, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 16'd1;
    end
  end

  // FIFO storage; contents are meaningless outside [r_rp, r_wp) so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wp] <= w_new;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow; a new overflow beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // Interrupt enable register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
    end else if (w_wr && (bus.address == ADDR_IRQ_MASK)) begin
      r_mask <= bus.writedata[1:0];
    end
  end

  // STATUS word assembled from current register state.
  always_comb begin
    w_status = '0;
    w_status[STATUS_STABLE_LSB +: NUM_KEYS] = w_stable;
    w_status[STATUS_COUNT_LSB +: CNTW]      = r_count;
    w_status[STATUS_OVF_BIT]                = r_ovf;
  end

  // Registered read data; holds its last value between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (w_rd) begin
      case (bus.address)
        ADDR_EVENT:    r_readdata <= w_empty ? 32'd0 : event_word(r_mem[r_rp]);
        ADDR_STATUS:   r_readdata <= w_status;
        ADDR_IRQ_MASK: r_readdata <= {30'd0, r_mask};
        default:       r_readdata <= 32'd0;
      endcase
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = (r_mask[0] && !w_empty) || (r_mask[1] && r_ovf);

endmodule

// File: tb/tb_key_event_ctrl.sv
// tb/tb_key_event_ctrl.sv - self-checking bench for key_event_ctrl with a window-based reference model
module tb_key_event_ctrl;
  import key_event_pkg::*;

  localparam int N     = 4;
  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] keys;
  int           n_checks = 0;
  int           n_errors = 0;

  key_event_ctrl_if bus ();

  key_event_ctrl #(
    .NUM_KEYS(N),
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (rst),
    .in_port(keys),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model state. m_lag[j] holds the pin value sampled j edges ago.
  logic [N-1:0] m_lag [1:D+1];
  logic [N-1:0] m_stable;
  logic [N-1:0] m_pending;
  logic [N-1:0] m_ptype;
  int           m_rr;
  logic [15:0]  m_ts;
  logic [31:0]  m_q [$];
  logic         m_ovf;
  logic [1:0]   m_mask;
  logic [31:0]  m_rdata;

  function automatic logic m_irq();
    return (m_mask[0] && (m_q.size() != 0)) || (m_mask[1] && m_ovf);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One rising edge of the reference model, using the inputs applied before it.
  task automatic model_step();
    logic rd, wr, pop, flush, clr, set;
    logic all_diff;
    int   g;
    if (rst) begin
      for (int j = 1; j <= D + 1; j++) m_lag[j] = '1;
      m_stable = '1; m_pending = '0; m_ptype = '0; m_rr = 0;
      m_q.delete(); m_ovf = 1'b0; m_mask = 2'b00; m_rdata = 32'd0; m_ts = 16'd0;
      return;
    end
    rd = bus.chipselect && !bus.read_n;
    wr = bus.chipselect && !bus.write_n;
    if (rd) begin
      case (bus.address)
        2'd0:    m_rdata = (m_q.size() != 0) ? m_q[0] : 32'd0;
        2'd1:    m_rdata = {15'd0, m_ovf, 3'd0, 5'(m_q.size()), 4'd0, m_stable};
        2'd2:    m_rdata = {30'd0, m_mask};
        default: m_rdata = 32'd0;
      endcase
    end
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && m_pending[(m_rr + k) % N]) g = (m_rr + k) % N;
    end
    pop   = rd && bus.address == 2'd0 && m_q.size() != 0;
    flush = wr && bus.address == 2'd3 && bus.writedata[0];
    clr   = wr && bus.address == 2'd3 && bus.writedata[1];
    set   = 1'b0;
    if (flush) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (g >= 0) begin
        if (m_q.size() < DEPTH)
          m_q.push_back(32'h8000_0000 | (32'(m_ts) << 8) | (32'(m_ptype[g]) << 4) | 32'(g));
        else
          set = 1'b1;
      end
    end
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (wr && bus.address == 2'd2) m_mask = bus.writedata[1:0];
    if (g >= 0) begin
      m_pending[g] = 1'b0;
      m_rr = (g + 1) % N;
    end
    // A level is accepted once the last D synchronised samples all disagree with it.
    for (int i = 0; i < N; i++) begin
      all_diff = 1'b1;
      for (int j = 2; j <= D + 1; j++) if (m_lag[j][i] == m_stable[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_stable[i]  = m_lag[2][i];
        m_pending[i] = 1'b1;
        m_ptype[i]   = ~m_lag[2][i];
      end
    end
    for (int j = D + 1; j >= 2; j--) m_lag[j] = m_lag[j-1];
    m_lag[1] = keys;
    m_ts = m_ts + 16'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] addr);
    bus.address = addr; bus.chipselect = 1'b1; bus.read_n = 1'b0;
    tick();
    bus_idle();
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.address = addr; bus.writedata = data; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    tick();
    bus_idle();
  endtask

  task automatic read_chk(input string tag, input logic [1:0] addr, input logic [31:0] want);
    bus_read(addr);
    check({tag, "_model"}, bus.readdata, m_rdata);
    check(tag, bus.readdata, want);
  endtask

  task automatic irq_chk(input string tag, input logic want);
    check({tag, "_model"}, {31'd0, bus.irq}, {31'd0, m_irq()});
    check(tag, {31'd0, bus.irq}, {31'd0, want});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] e0, e1;
    logic        did_read;
    int          r;
    keys = '1; rst = 1'b1; bus.address = 2'd0; bus.writedata = 32'd0;
    bus_idle();
    ticks(3);
    check("rst_readdata", bus.readdata, 32'd0);
    irq_chk("rst_irq", 1'b0);

    // KEY1 press: accepted at edge 6, pushed at edge 7 with ts 6.
    rst = 1'b0; keys = 4'b1101;
    ticks(6);
    read_chk("k1_status_e7", ADDR_STATUS, 32'h0000_000D);
    read_chk("k1_status_e8", ADDR_STATUS, 32'h0000_010D);
    read_chk("k1_event", ADDR_EVENT, 32'h8000_0611);
    keys = 4'b1111;
    ticks(8);
    bus_read(ADDR_EVENT);
    check("k1_release_model", bus.readdata, m_rdata);
    check("k1_release_low", bus.readdata & 32'h8000_00FF, 32'h8000_0001);

    // Short glitch on KEY0 must not produce an event.
    bus_write(ADDR_IRQ_MASK, 32'd1);
    keys = 4'b1110;
    ticks(3);
    keys = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      irq_chk("glitch_irq", 1'b0);
    end
    read_chk("glitch_status", ADDR_STATUS, 32'h0000_000F);

    // KEY0 and KEY2 together from rr=0.
    rst = 1'b1; ticks(2); rst = 1'b0;
    keys = 4'b1010;
    ticks(8);
    check("rr_after_two", 32'(dut.r_rr), 32'd3);
    read_chk("dual_e0", ADDR_EVENT, 32'h8000_0610);
    e0 = bus.readdata;
    read_chk("dual_e1", ADDR_EVENT, 32'h8000_0712);
    e1 = bus.readdata;
    check("dual_ts_diff", ((e1 >> 8) & 32'hFFFF) - ((e0 >> 8) & 32'hFFFF), 32'd1);

    // Five events without reads: four fit, the fifth overflows.
    bus_write(ADDR_IRQ_MASK, 32'd2);
    keys = 4'b0101;
    ticks(12);
    keys = 4'b0100;
    ticks(10);
    read_chk("ovf_status", ADDR_STATUS, 32'h0001_0404);
    irq_chk("ovf_irq", 1'b1);
    bus_write(ADDR_CONTROL, 32'd2);
    read_chk("ovf_clr_status", ADDR_STATUS, 32'h0000_0404);
    irq_chk("ovf_clr_irq", 1'b0);
    bus_write(ADDR_CONTROL, 32'd1);
    read_chk("flush_status", ADDR_STATUS, 32'h0000_0004);

    // Empty read, then pop and push on the same edge while full.
    read_chk("empty_event", ADDR_EVENT, 32'd0);
    read_chk("empty_status", ADDR_STATUS, 32'h0000_0004);
    keys = 4'b1011;
    ticks(14);
    read_chk("full_status", ADDR_STATUS, 32'h0000_040B);
    keys = 4'b1010;
    ticks(6);
    bus_read(ADDR_EVENT);
    check("full_pop_model", bus.readdata, m_rdata);
    read_chk("full_push_pop_status", ADDR_STATUS, 32'h0000_040A);

    // Reset mid-debounce on KEY3, then hold it through reset release.
    keys = 4'b1111;
    ticks(10);
    bus_write(ADDR_CONTROL, 32'd1);
    keys = 4'b0111;
    ticks(4);
    bus_read(ADDR_STATUS);
    rst = 1'b1;
    tick();
    check("midrst_readdata", bus.readdata, 32'd0);
    irq_chk("midrst_irq", 1'b0);
    rst = 1'b0;
    read_chk("midrst_status_e1", ADDR_STATUS, 32'h0000_000F);
    ticks(5);
    read_chk("midrst_status_e7", ADDR_STATUS, 32'h0000_0007);
    read_chk("midrst_status_e8", ADDR_STATUS, 32'h0000_0107);
    read_chk("midrst_event", ADDR_EVENT, 32'h8000_0613);

    // Randomised traffic against the model.
    rst = 1'b1; keys = '1; ticks(2); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) keys = keys ^ (N'(1) << $urandom_range(0, N - 1));
      r = $urandom_range(0, 15);
      did_read = 1'b0;
      bus.address = 2'($urandom_range(0, 3));
      if (r < 4) begin
        bus.chipselect = 1'b1; bus.read_n = 1'b0; did_read = 1'b1;
      end else if (r == 4) begin
        bus.writedata = $urandom;
        if (bus.address == ADDR_CONTROL && $urandom_range(0, 3) != 0) bus.writedata[0] = 1'b0;
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
      end
      tick();
      bus_idle();
      if (did_read) check("rnd_read", bus.readdata, m_rdata);
      check("rnd_irq", {31'd0, bus.irq}, {31'd0, m_irq()});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
